// File: rtl/pipeline_step_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_step_ctrl
//   Debug-side controller driving the global pipeline advance enable. Decodes
//   debug UART command bytes into run / single-step / burst / pause, stops on
//   the HALT flag that arrives at write-back, and after every run segment asks
//   the debug transmitter for a state dump and waits for its ack.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high (priority over everything)
//   i_cmd_valid   one-cycle strobe, i_cmd holds a received byte
//   i_cmd         command / argument byte
//   i_halt        HALT instruction has reached write-back
//   i_report_ack  transmitter finished the state dump
//   o_step        pipeline advance enable to every pipeline latch
//   o_report_req  level request for a state dump, held until ack
//   o_halted      sticky: program has executed HALT
//   o_busy        high in every state except IDLE and HALTED
//   o_cmd_drop    one-cycle pulse: a command byte was ignored
//   o_step_count  number of cycles with o_step=1 (wraps)
// -----------------------------------------------------------------------------
module pipeline_step_ctrl #(
    parameter logic [7:0]  CMD_RUN   = 8'h63,
    parameter logic [7:0]  CMD_STEP  = 8'h73,
    parameter logic [7:0]  CMD_BURST = 8'h62,
    parameter logic [7:0]  CMD_PAUSE = 8'h70,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  logic [7:0]       i_cmd,
    input  logic             i_halt,
    input  logic             i_report_ack,
    output logic             o_step,
    output logic             o_report_req,
    output logic             o_halted,
    output logic             o_busy,
    output logic             o_cmd_drop,
    output logic [CNT_W-1:0] o_step_count
);

    localparam int unsigned ARG_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_STEP      = 3'd2,
        S_BURST_ARG = 3'd3,
        S_BURST     = 3'd4,
        S_REPORT    = 3'd5,
        S_HALTED    = 3'd6
    } state_e;

    state_e             state_q,      state_d;
    logic [ARG_W-1:0]   remaining_q,  remaining_d;
    logic               halted_q,     halted_d;
    logic               drop_q,       drop_d;
    logic               step_q,       step_d;
    logic               report_req_q, report_req_d;
    logic               busy_q,       busy_d;
    logic [CNT_W-1:0]   step_count_q, step_count_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            halted_q     <= 1'b0;
            drop_q       <= 1'b0;
            step_q       <= 1'b0;
            report_req_q <= 1'b0;
            busy_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            halted_q     <= halted_d;
            drop_q       <= drop_d;
            step_q       <= step_d;
            report_req_q <= report_req_d;
            busy_q       <= busy_d;
            step_count_q <= step_count_d;
        end
    end

    // Next-state logic; outputs are registered decodes of the next state so
    // they always equal a decode of the state register with no input path.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drop_d      = 1'b0;
        halted_d    = halted_q | i_halt;

        case (state_q)
            S_IDLE: begin
                if (i_halt) begin
                    // halt wins over a command arriving in the same cycle
                    state_d = S_REPORT;
                    drop_d  = i_cmd_valid;
                end else if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_RUN:   state_d = S_RUN;
                        CMD_STEP:  state_d = S_STEP;
                        CMD_BURST: state_d = S_BURST_ARG;
                        default:   drop_d  = 1'b1;
                    endcase
                end
            end

            S_RUN: begin
                if (i_halt) begin
                    state_d = S_REPORT;
                    drop_d  = i_cmd_valid;
                end else if (i_cmd_valid) begin
                    if (i_cmd == CMD_PAUSE) begin
                        state_d = S_REPORT;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end

            S_STEP: begin
                state_d = S_REPORT;
                drop_d  = i_cmd_valid;
            end

            // Byte here is a raw step count, never a command
            S_BURST_ARG: begin
                if (i_halt) begin
                    state_d = S_REPORT;
                    drop_d  = i_cmd_valid;
                end else if (i_cmd_valid) begin
                    if (i_cmd == ARG_W'(0)) begin
                        state_d = S_IDLE;
                    end else begin
                        remaining_d = i_cmd;
                        state_d     = S_BURST;
                    end
                end
            end

            // remaining counts the step cycles left including this one
            S_BURST: begin
                remaining_d = remaining_q - ARG_W'(1);
                drop_d      = i_cmd_valid;
                if ((remaining_q == ARG_W'(1)) || i_halt) begin
                    remaining_d = '0;
                    state_d     = S_REPORT;
                end
            end

            S_REPORT: begin
                drop_d = i_cmd_valid;
                if (i_report_ack) begin
                    state_d = halted_d ? S_HALTED : S_IDLE;
                end
            end

            S_HALTED: begin
                drop_d = i_cmd_valid;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        step_d       = (state_d == S_RUN) || (state_d == S_STEP) ||
                       (state_d == S_BURST);
        report_req_d = (state_d == S_REPORT);
        busy_d       = (state_d != S_IDLE) && (state_d != S_HALTED);
        step_count_d = step_count_q + CNT_W'(step_q);
    end

    assign o_step       = step_q;
    assign o_report_req = report_req_q;
    assign o_halted     = halted_q;
    assign o_busy       = busy_q;
    assign o_cmd_drop   = drop_q;
    assign o_step_count = step_count_q;

endmodule
